// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one spi_master byte engine between NUM_REQ byte
// sources, with bounded bursts and one byte in flight so every rx byte has a known owner.
module spi_req_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_empty,
  output logic [NUM_REQ-1:0]   req_rden,
  input  logic [NUM_REQ-1:0]   req_en,
  output logic [7:0]           m_tx_data,
  output logic                 m_tx_empty,
  input  logic                 m_tx_rden,
  input  logic [7:0]           m_rx_data,
  input  logic                 m_rx_valid,
  output logic [7:0]           rx_data,
  output logic [NUM_REQ-1:0]   rx_valid,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 busy,
  output logic                 err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] gidx_q, gidx_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic          pending_q, pending_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic          err_q, err_d;

  logic [NUM_REQ-1:0] elig;
  logic [IW-1:0]      pick_idx;
  logic [IW-1:0]      next_ptr;
  logic               cur_empty;
  logic               cur_en;
  logic               burst_done;
  logic               last_byte;
  logic               rx_hit;
  logic               release_now;

  assign elig       = req_en & ~req_empty;
  assign cur_empty  = req_empty[gidx_q];
  assign cur_en     = req_en[gidx_q];
  assign burst_done = (burst_cnt_q == BW'(MAX_BURST));
  assign last_byte  = ((burst_cnt_q + BW'(1)) == BW'(MAX_BURST));
  assign rx_hit     = (state_q == SERVE) & pending_q & m_rx_valid;
  assign next_ptr   = (gidx_q == IW'(NUM_REQ - 1)) ? '0 : gidx_q + IW'(1);

  // A byte returned in the same cycle as a new pop leaves a byte in flight,
  // so the grant must be held to keep that next byte's owner known.
  assign release_now = (state_q == SERVE) & ~m_tx_rden &
                       ((rx_hit & (last_byte | cur_empty | ~cur_en)) |
                        (~pending_q & cur_empty));

  // Scan downward so the lowest offset from rr_ptr is the one that sticks.
  always_comb begin
    pick_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (elig[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        pick_idx = IW'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q     <= IDLE;
      gidx_q      <= '0;
      rr_ptr_q    <= '0;
      pending_q   <= 1'b0;
      burst_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gidx_q      <= gidx_d;
      rr_ptr_q    <= rr_ptr_d;
      pending_q   <= pending_d;
      burst_cnt_q <= burst_cnt_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gidx_d      = gidx_q;
    rr_ptr_d    = rr_ptr_q;
    pending_d   = pending_q;
    burst_cnt_d = burst_cnt_q;
    err_d       = err_q | (m_rx_valid & ~pending_q);
    case (state_q)
      IDLE: begin
        if (|elig) begin
          state_d     = SERVE;
          gidx_d      = pick_idx;
          burst_cnt_d = '0;
        end
      end
      SERVE: begin
        if (rx_hit) burst_cnt_d = burst_cnt_q + BW'(1);
        if (m_tx_rden)   pending_d = 1'b1;
        else if (rx_hit) pending_d = 1'b0;
        if (release_now) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Toward spi_master, a byte is offered while m_tx_empty is low and is taken in
  // any cycle m_tx_rden is high; that same cycle pops the owning requester FIFO.
  always_comb begin
    req_rden   = '0;
    rx_valid   = '0;
    rx_data    = '0;
    m_tx_data  = '0;
    m_tx_empty = 1'b1;
    grant      = '0;
    if (state_q == SERVE) begin
      m_tx_data        = req_data[8*gidx_q +: 8];
      m_tx_empty       = cur_empty | pending_q | burst_done;
      req_rden[gidx_q] = m_tx_rden;
      grant[gidx_q]    = 1'b1;
    end
    if (rx_hit) begin
      rx_data          = m_rx_data;
      rx_valid[gidx_q] = 1'b1;
    end
  end

  assign busy = (state_q != IDLE);
  assign err  = err_q;

endmodule

// File: tb/tb_spi_req_arbiter.sv
// Bench for spi_req_arbiter: FIFO and spi_master models around the DUT, with a
// transaction-level round-robin plan as the expected byte/owner sequence.
module tb_spi_req_arbiter;

  localparam int NR = 4;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst_l;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_empty;
  logic [NR-1:0]   req_rden;
  logic [NR-1:0]   req_en;
  logic [7:0]      m_tx_data;
  logic            m_tx_empty;
  logic            m_tx_rden;
  logic [7:0]      m_rx_data;
  logic            m_rx_valid;
  logic [7:0]      rx_data;
  logic [NR-1:0]   rx_valid;
  logic [NR-1:0]   grant;
  logic            busy;
  logic            err;

  spi_req_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .rst_l      (rst_l),
    .req_data   (req_data),
    .req_empty  (req_empty),
    .req_rden   (req_rden),
    .req_en     (req_en),
    .m_tx_data  (m_tx_data),
    .m_tx_empty (m_tx_empty),
    .m_tx_rden  (m_tx_rden),
    .m_rx_data  (m_rx_data),
    .m_rx_valid (m_rx_valid),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .grant      (grant),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Environment and scoreboard state; exp_q items are {requester[2:0], byte[7:0]}.
  logic [7:0]    fifo [NR][$];
  logic [10:0]   exp_q[$];
  logic [NR-1:0] grant_log[$];
  logic [NR-1:0] prev_grant;
  logic [NR-1:0] en_v;
  logic [7:0]    mst_miso;
  bit            mst_busy;
  int            mst_cnt;
  int            mst_owner;
  bit            spur;
  bit            err_exp;
  int            mdl_ptr;
  bit            dis_armed;
  int            dis_pops;
  int            rx_cnt;
  int            n_cmp;
  int            n_mis;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit any_elig();
    for (int i = 0; i < NR; i++) if (en_v[i] && fifo[i].size() != 0) return 1'b1;
    return 1'b0;
  endfunction

  // Round-robin plan from the rules: from the pointer, first enabled non-empty
  // source gets min(MAX_BURST, remaining) bytes, then the pointer moves past it.
  function automatic void build_exp(input int skip_req, input int skip_n);
    int rem[NR];
    int off[NR];
    int found;
    int idx;
    int n;
    for (int i = 0; i < NR; i++) begin
      rem[i] = fifo[i].size();
      off[i] = 0;
    end
    rem[skip_req] -= skip_n;
    off[skip_req] += skip_n;
    for (int g = 0; g < 200; g++) begin
      found = -1;
      for (int k = 0; k < NR; k++) begin
        idx = (mdl_ptr + k) % NR;
        if (found < 0 && en_v[idx] && rem[idx] > 0) found = idx;
      end
      if (found < 0) break;
      n = (rem[found] < MB) ? rem[found] : MB;
      for (int j = 0; j < n; j++) exp_q.push_back({3'(found), fifo[found][off[found] + j]});
      off[found] += n;
      rem[found] -= n;
      mdl_ptr = (found + 1) % NR;
    end
  endfunction

  task automatic monitor();
    logic [10:0] it;
    check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    check("busy_vs_grant", 32'(busy), 32'(grant != '0));
    check("err_sticky", 32'(err), 32'(err_exp));
    if (m_rx_valid && mst_busy) begin
      check("rx_valid", 32'(rx_valid), 32'(1 << mst_owner));
      check("rx_data", 32'(rx_data), 32'(mst_miso));
      mst_busy = 1'b0;
      rx_cnt++;
    end else begin
      check("rx_valid_quiet", 32'(rx_valid), 32'd0);
      if (m_rx_valid) err_exp = 1'b1;
    end
    if (m_tx_rden) begin
      check("pop_expected", 32'(exp_q.size() != 0), 32'd1);
      mst_owner = 0;
      if (exp_q.size() != 0) begin
        it = exp_q.pop_front();
        check("req_rden", 32'(req_rden), 32'(1 << it[10:8]));
        check("grant", 32'(grant), 32'(1 << it[10:8]));
        check("mosi", 32'(m_tx_data), 32'(it[7:0]));
        mst_owner = int'(it[10:8]);
      end
      mst_busy = 1'b1;
      mst_cnt  = $urandom_range(1, 4);
      mst_miso = 8'($urandom);
    end else begin
      check("req_rden_idle", 32'(req_rden), 32'd0);
    end
    for (int i = 0; i < NR; i++) begin
      if (req_rden[i] && fifo[i].size() != 0) begin
        void'(fifo[i].pop_front());
        if (dis_armed && i == 0) begin
          dis_pops++;
          if (dis_pops == 2) en_v[0] = 1'b0;
        end
      end
    end
    if (grant != prev_grant && grant != '0) grant_log.push_back(grant);
    prev_grant = grant;
  endtask

  // One cycle: drive at the falling edge, let spi_master react to m_tx_empty, then observe.
  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      req_empty[i]      = (fifo[i].size() == 0);
      req_data[8*i +: 8] = (fifo[i].size() != 0) ? fifo[i][0] : 8'h00;
    end
    req_en     = en_v;
    m_tx_rden  = 1'b0;
    m_rx_valid = 1'b0;
    m_rx_data  = 8'h00;
    if (mst_busy) begin
      if (mst_cnt == 0) begin
        m_rx_valid = 1'b1;
        m_rx_data  = mst_miso;
      end else begin
        mst_cnt--;
      end
    end else if (spur) begin
      m_rx_valid = 1'b1;
      m_rx_data  = 8'hEE;
      spur       = 1'b0;
    end
    #1;
    if (rst_l && !mst_busy && !m_tx_empty) m_tx_rden = 1'b1;
    #1;
    monitor();
  endtask

  task automatic drain(input string tag);
    int cyc;
    cyc = 0;
    step();
    while ((busy || mst_busy || any_elig()) && cyc < 3000) begin
      step();
      cyc++;
    end
    check({tag, "_drain"}, 32'(cyc < 3000), 32'd1);
    check({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic reset_pulse();
    rst_l = 1'b0;
    for (int i = 0; i < NR; i++) fifo[i].delete();
    exp_q.delete();
    mst_busy = 1'b0;
    mdl_ptr  = 0;
    err_exp  = 1'b0;
    step();
    step();
    rst_l = 1'b1;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] tmp_q[$];
    int rx0;
    int keep;
    n_cmp = 0; n_mis = 0; rx_cnt = 0; mdl_ptr = 0; err_exp = 1'b0;
    mst_busy = 1'b0; mst_cnt = 0; mst_owner = 0; spur = 1'b0;
    dis_armed = 1'b0; dis_pops = 0; prev_grant = '0; en_v = '0;
    req_data = '0; req_empty = '1; req_en = '0;
    m_tx_rden = 1'b0; m_rx_valid = 1'b0; m_rx_data = 8'h00;
    rst_l = 1'b0;

    // Reset values
    step();
    step();
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tx_empty", 32'(m_tx_empty), 32'd1);
    check("rst_tx_data", 32'(m_tx_data), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst_l = 1'b1;

    // Single requester: req1 holds A5, 3C
    en_v = 4'hF;
    fifo[1].push_back(8'hA5);
    fifo[1].push_back(8'h3C);
    build_exp(0, 0);
    rx0 = rx_cnt;
    step();
    check("t1_grant_first", 32'(grant), 32'd0);
    check("t1_tx_empty_first", 32'(m_tx_empty), 32'd1);
    step();
    check("t1_grant", 32'(grant), 32'b0010);
    drain("t1");
    check("t1_rx_count", 32'(rx_cnt - rx0), 32'd2);
    check("t1_busy_end", 32'(busy), 32'd0);

    // Round robin from a fresh pointer: 6 bytes each
    reset_pulse();
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < 6; j++) fifo[i].push_back(8'($urandom));
    grant_log.delete();
    build_exp(0, 0);
    drain("t2");
    check("t2_bursts", 32'(grant_log.size()), 32'd8);
    for (int k = 0; k < grant_log.size() && k < 8; k++)
      check("t2_order", 32'(grant_log[k]), 32'(1 << (k % NR)));

    // Mask 1011, requester 2 enabled while requester 1 holds the grant
    en_v = 4'b1011;
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < 6; j++) fifo[i].push_back(8'($urandom));
    grant_log.delete();
    build_exp(0, 0);
    for (int k = 0; k < 200 && grant != 4'b0010; k++) step();
    check("t3_req1_granted", 32'(grant), 32'b0010);
    check("t3_req2_untouched", 32'(fifo[2].size()), 32'd6);
    keep = 0;
    while (keep < exp_q.size() && exp_q[keep][10:8] == 3'd1) keep++;
    tmp_q.delete();
    for (int k = 0; k < keep; k++) tmp_q.push_back(exp_q[k]);
    exp_q   = tmp_q;
    en_v[2] = 1'b1;
    mdl_ptr = 2;
    build_exp(1, keep);
    drain("t3");
    check("t3_bursts", 32'(grant_log.size() >= 3), 32'd1);
    if (grant_log.size() >= 3) begin
      check("t3_first", 32'(grant_log[0]), 32'b0001);
      check("t3_second", 32'(grant_log[1]), 32'b0010);
      check("t3_next_rotation", 32'(grant_log[2]), 32'b0100);
    end

    // Disable mid-burst: req0 cleared while its 2nd byte is in flight
    en_v = 4'hF;
    for (int j = 0; j < 4; j++) fifo[0].push_back(8'($urandom));
    exp_q.push_back({3'd0, fifo[0][0]});
    exp_q.push_back({3'd0, fifo[0][1]});
    dis_armed = 1'b1;
    dis_pops  = 0;
    rx0       = rx_cnt;
    drain("t4");
    dis_armed = 1'b0;
    check("t4_pops", 32'(dis_pops), 32'd2);
    check("t4_rx_count", 32'(rx_cnt - rx0), 32'd2);
    check("t4_left", 32'(fifo[0].size()), 32'd2);
    mdl_ptr = 1;
    en_v    = 4'hF;
    build_exp(0, 0);
    drain("t4b");

    // Spurious rx while idle
    spur = 1'b1;
    step();
    step();
    check("t5_err", 32'(err), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);

    // Randomised traffic
    for (int s = 0; s < 12; s++) begin
      en_v = 4'($urandom_range(1, 15));
      for (int i = 0; i < NR; i++) begin
        int n;
        n = $urandom_range(0, 7);
        for (int j = 0; j < n; j++) fifo[i].push_back(8'($urandom));
      end
      build_exp(0, 0);
      drain("rand");
    end
    check("t5_err_still", 32'(err), 32'd1);

    // Reset while a byte is in flight
    en_v = 4'hF;
    for (int j = 0; j < 3; j++) fifo[0].push_back(8'($urandom));
    build_exp(0, 0);
    for (int k = 0; k < 50 && !mst_busy; k++) step();
    check("t6_pending", 32'(mst_busy), 32'd1);
    rst_l = 1'b0;
    #1;
    check("t6_grant", 32'(grant), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_tx_empty", 32'(m_tx_empty), 32'd1);
    check("t6_req_rden", 32'(req_rden), 32'd0);
    check("t6_rx_valid", 32'(rx_valid), 32'd0);
    check("t6_tx_data", 32'(m_tx_data), 32'd0);
    check("t6_rx_data", 32'(rx_data), 32'd0);
    check("t6_err", 32'(err), 32'd0);
    reset_pulse();
    fifo[3].push_back(8'h5A);
    fifo[3].push_back(8'hC3);
    build_exp(0, 0);
    step();
    check("t6_grant_first", 32'(grant), 32'd0);
    step();
    check("t6_grant_req3", 32'(grant), 32'b1000);
    drain("t6");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/spi_req_arbiter.md
Name: spi_req_arbiter

Overview:
Shares one spi_master byte engine between NUM_REQ independent byte sources, such as per-peripheral TX FIFOs, using round-robin arbitration with bounded bursts. It sits between the requesters' FIFO read ports and spi_master's tx_data/tx_empty/tx_rden port. Each received byte (rx_data/rx_valid) is routed back to the requester that owns the byte. At most one byte is in flight at a time, so ownership of every returned byte is unambiguous.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MAX_BURST, 4, maximum bytes served per grant before arbitration reopens (1..255)

Ports:
clk  in  1  system clock; all logic on rising edge
rst_l  in  1  asynchronous active-low reset
req_data  in  8*NUM_REQ  byte from requester i at bits [8i+7:8i]
req_empty  in  NUM_REQ  requester i FIFO empty
req_rden  out  NUM_REQ  pop strobe to requester i FIFO
req_en  in  NUM_REQ  per-requester enable mask
m_tx_data  out  8  byte to spi_master tx_data
m_tx_empty  out  1  to spi_master tx_empty
m_tx_rden  in  1  spi_master tx_rden
m_rx_data  in  8  spi_master rx_data
m_rx_valid  in  1  spi_master rx_valid
rx_data  out  8  received byte, broadcast to all requesters
rx_valid  out  NUM_REQ  one-hot strobe to the owning requester
grant  out  NUM_REQ  one-hot current owner; 0 when idle
busy  out  1  high whenever state is not IDLE
err  out  1  sticky flag: m_rx_valid arrived with nothing pending

Behaviour:
- Reset (async, rst_l=0):
  - state=IDLE, grant=0, rr_ptr=0, pending=0, burst_cnt=0, err=0.
  - Outputs: m_tx_empty=1, req_rden=0, rx_valid=0, busy=0, m_tx_data=0, rx_data=0.
  - Reset mid-transfer discards the ownership of any in-flight byte. No rx_valid is generated for it.
- Eligible set: elig[i] = req_en[i] & ~req_empty[i].
- IDLE:
  - If elig is nonzero, select the first eligible index searching upward from rr_ptr with wrap.
  - Register grant to that index, clear burst_cnt, go to SERVE.
  - Grant is visible the cycle after elig first rises; m_tx_empty can fall no earlier than that cycle.
- SERVE:
  - m_tx_data = req_data[grant].
  - m_tx_empty = req_empty[grant] | pending | burst_done. burst_done = (burst_cnt == MAX_BURST).
  - req_rden[grant] = m_tx_rden. req_rden is 0 for all other requesters.
  - m_tx_rden sets pending next cycle.
  - m_rx_valid with pending set:
    - rx_data = m_rx_data and rx_valid[grant] = 1, both combinational in the same cycle.
    - Clear pending and increment burst_cnt.
  - Release check, evaluated on the m_rx_valid cycle. Release if any of these hold:
    - burst_cnt+1 == MAX_BURST
    - req_empty[grant] = 1
    - req_en[grant] = 0
  - On release: go to IDLE, rr_ptr = (grant+1) mod NUM_REQ, grant cleared next cycle. Otherwise stay in SERVE.
- Same-cycle m_tx_rden and m_rx_valid (spi_master does not produce this): pending ends set, the rx byte is delivered, and release is suppressed.
- Disable mid-burst: the in-flight byte completes and is delivered. Release then occurs at that byte's m_rx_valid.
- Requester goes empty with nothing pending in SERVE: release immediately to IDLE with rr_ptr advanced, so a drained source cannot hog the engine.
- m_rx_valid while pending=0 (any state):
  - Byte dropped, rx_valid stays 0, err set.
  - err clears only on reset.
- Arbitration is fair: a continuously eligible requester waits at most (NUM_REQ-1) bursts.
- burst_cnt width is clog2(MAX_BURST+1). No wrap is possible, since release happens at MAX_BURST.

Test Plan:
- Single requester: req1 holds 0xA5,0x3C with MAX_BURST=4. Expect grant=0010, two req_rden[1] pulses, and MOSI bytes A5 then 3C. rx_valid[1] pulses twice with the MISO bytes, then release to IDLE and busy=0.
- Round-robin: all 4 requesters hold 6 bytes each with MAX_BURST=4. Expect grant order 0,1,2,3,0,1,2,3. Bursts are 4,4,4,4 then 2,2,2,2 bytes. rx_valid is always one-hot and matches grant.
- Mask: req_en=1011, all requesters non-empty. Requester 2 is never granted and req_rden[2] stays 0. Set req_en[2]=1 mid-run; requester 2 is granted in the next rotation.
- Disable mid-burst: clear req_en[0] during the 2nd byte of req0's burst. The 2nd byte's rx_valid[0] is delivered, then release. No 3rd req_rden[0] occurs.
- Spurious rx: pulse m_rx_valid in IDLE. Expect err=1, rx_valid=0000, and state unaffected. err stays 1 until rst_l is low.
- Reset mid-op: assert rst_l=0 while pending=1. Outputs return to reset values immediately (asynchronously). After release of reset, with requester 3 non-empty, grant=1000 on the first arbitration, since rr_ptr=0 scans 0..3.
